// File: rtl/inst_decode_stage.sv
// inst_decode_stage: RV32I decoder feeding a DEPTH-entry FIFO of decoded entries.
module inst_decode_stage #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_inst,
  input  logic [XLEN-1:0]          in_pc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [4:0]               out_rs1,
  output logic [4:0]               out_rs2,
  output logic [4:0]               out_rd,
  output logic [6:0]               out_opcode,
  output logic [3:0]               out_func,
  output logic [XLEN-1:0]          out_imm,
  output logic [2:0]               out_fmt,
  output logic                     out_use_rs1,
  output logic                     out_use_rs2,
  output logic                     out_wr_rd,
  output logic                     out_illegal,
  output logic [XLEN-1:0]          out_pc,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  typedef struct packed {
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [6:0]      opcode;
    logic [3:0]      func;
    logic [XLEN-1:0] imm;
    logic [2:0]      fmt;
    logic            use_rs1;
    logic            use_rs2;
    logic            wr_rd;
    logic            illegal;
    logic [XLEN-1:0] pc;
  } ent_t;
  ent_t dec, head;
  ent_t mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [31:0] i;
  logic [2:0] fmt;
  logic u1, u2, has_rd, push, pop;
  assign i = in_inst;
  always_comb begin
    case (i[6:0])
      7'b0110011:                                                 fmt = 3'd0;
      7'b0010011, 7'b0000011, 7'b1100111, 7'b0001111, 7'b1110011: fmt = 3'd1;
      7'b0100011:                                                 fmt = 3'd2;
      7'b1100011:                                                 fmt = 3'd3;
      7'b0110111, 7'b0010111:                                     fmt = 3'd4;
      7'b1101111:                                                 fmt = 3'd5;
      default:                                                    fmt = 3'd7;
    endcase
  end
  assign u1     = fmt inside {3'd0, 3'd1, 3'd2, 3'd3};
  assign u2     = fmt inside {3'd0, 3'd2, 3'd3};
  assign has_rd = fmt inside {3'd0, 3'd1, 3'd4, 3'd5};
  always_comb begin
    dec.rs1     = u1 ? i[19:15] : 5'd0;
    dec.rs2     = u2 ? i[24:20] : 5'd0;
    dec.rd      = has_rd ? i[11:7] : 5'd0;
    dec.opcode  = i[6:0];
    // func[0] only distinguishes sub/sra and srai from their siblings
    dec.func    = {fmt <= 3'd3 ? i[14:12] : 3'd0,
                   (fmt == 3'd0 || (i[6:0] == 7'b0010011 && i[13:12] == 2'b01)) ? i[30] : 1'b0};
    dec.imm     = fmt == 3'd1 ? XLEN'($signed(i[31:20])) :
                  fmt == 3'd2 ? XLEN'($signed({i[31:25], i[11:7]})) :
                  fmt == 3'd3 ? XLEN'($signed({i[31], i[7], i[30:25], i[11:8], 1'b0})) :
                  fmt == 3'd4 ? XLEN'($signed({i[31:12], 12'h000})) :
                  fmt == 3'd5 ? XLEN'($signed({i[31], i[19:12], i[20], i[30:21], 1'b0})) : '0;
    dec.fmt     = fmt;
    dec.use_rs1 = u1;
    dec.use_rs2 = u2;
    dec.wr_rd   = has_rd && i[11:7] != 5'd0;
    dec.illegal = fmt == 3'd7;
    dec.pc      = in_pc;
  end
  assign in_ready  = count < FULL;
  assign out_valid = count != '0;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  always_ff @(posedge clk)
    if (push) mem[wp] <= dec;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else if (flush) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  // storage is not reset; gating with out_valid keeps outputs zero when empty
  assign head        = out_valid ? mem[rp] : '0;
  assign out_rs1     = head.rs1;
  assign out_rs2     = head.rs2;
  assign out_rd      = head.rd;
  assign out_opcode  = head.opcode;
  assign out_func    = head.func;
  assign out_imm     = head.imm;
  assign out_fmt     = head.fmt;
  assign out_use_rs1 = head.use_rs1;
  assign out_use_rs2 = head.use_rs2;
  assign out_wr_rd   = head.wr_rd;
  assign out_illegal = head.illegal;
  assign out_pc      = head.pc;
endmodule

// File: doc/inst_decode_stage.md
INST_DECODE_STAGE -- requirements
Module: inst_decode_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning data-path width; immediates sign-extended to XLEN (32 or 64).
REQ-002 SHALL have parameter DEPTH, default 2, meaning decoded-entry queue depth; power of two, minimum 2.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on the rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port flush  input  1  synchronous queue clear.
REQ-006 SHALL have port in_valid  input  1  instruction offered.
REQ-007 SHALL have port in_ready  output  1  stage accepts the offered instruction.
REQ-008 SHALL have port in_inst  input  32  raw RV32I instruction word.
REQ-009 SHALL have port in_pc  input  XLEN  PC of in_inst, carried unchanged.
REQ-010 SHALL have port out_valid  output  1  head entry valid.
REQ-011 SHALL have port out_ready  input  1  consumer takes the head entry.
REQ-012 SHALL have ports out_rs1, out_rs2, out_rd  output  5 each  register indices.
REQ-013 SHALL have port out_opcode  output  7  inst[6:0].
REQ-014 SHALL have port out_func  output  4  {funct3, inst[30]}.
REQ-015 SHALL have port out_imm  output  XLEN  sign-extended immediate.
REQ-016 SHALL have port out_fmt  output  3  format: R=0, I=1, S=2, B=3, U=4, J=5, illegal=7.
REQ-017 SHALL have ports out_use_rs1, out_use_rs2, out_wr_rd  output  1 each  operand/writeback flags.
REQ-018 SHALL have ports out_illegal  output  1  and out_pc  output  XLEN.
REQ-019 SHALL have port count  output  clog2(DEPTH)+1  queue occupancy.

Function
REQ-020 SHALL decode opcodes: 0110011 R; 0010011, 0000011, 1100111 I; 0100011 S; 1100011 B; 0110111, 0010111 U; 1101111 J; 0001111, 1110011 I (fence/system).
REQ-021 SHALL build immediates per the ISA: I inst[31:20]; S {inst[31:25],inst[11:7]}; B {inst[31],inst[7],inst[30:25],inst[11:8],0}; J {inst[31],inst[19:12],inst[20],inst[30:21],0}; U {inst[31:12],12'h000}; R imm=0; all sign-extended from inst[31] to XLEN.
REQ-022 SHALL drive 0, never X, on unused fields: rs1/rs2/rd not used by the format are 0, with use flags clear; func=0 for U/J; func[0]=inst[30] only for R and OP-IMM funct3 001/101, else 0.
REQ-023 SHALL set wr_rd for R, I, U, J; clear it for S, B, illegal; rd=0 forces wr_rd=0.
REQ-024 SHALL flag illegal when inst[1:0]!=2'b11 or the opcode is unlisted: fmt=7, all flags 0, imm=0, pc carried.
REQ-025 SHALL push on the edge where in_valid && in_ready; latency one cycle: entry visible at out_* with out_valid=1 after that edge.
REQ-026 SHALL drive in_ready = (count < DEPTH), with no combinational path from out_ready.
REQ-027 SHALL pop on the edge where out_valid && out_ready; out_* always reflect the head entry; order is FIFO.
REQ-028 SHALL leave count unchanged on simultaneous push and pop; full with pop: no push that cycle (in_ready=0).
REQ-029 SHALL wrap read/write pointers modulo DEPTH.
REQ-030 SHALL hold out_* stable while out_valid && !out_ready.
REQ-031 SHALL make flush, when high, empty the queue (count=0) and discard any same-cycle push and pop; flush overrides both.

Reset
REQ-032 SHALL, on reset_n low, clear asynchronously count, pointers, out_valid, and all out_* fields to 0; in_ready=1 while in reset and after it.
REQ-033 SHALL discard queued entries on reset mid-operation, with no entry re-emitted after release.

Verification
REQ-034 SHALL push 0xFFF00093 (addi x1,x0,-1) -> next cycle out_valid=1, rd=1, rs1=0, imm=0xFFFFFFFF, func=0, fmt=1, wr_rd=1, use_rs2=0.
REQ-035 SHALL push 0x00512423 (sw x5,8(x2)) -> rs1=2, rs2=5, rd=0, imm=8, func=4'b0100, fmt=2, wr_rd=0; push 0xFE000EE3 (beq x0,x0,-4) -> imm=0xFFFFFFFC, fmt=3.
REQ-036 SHALL push 0x008000EF (jal x1,8) -> imm=8, fmt=5, rd=1; push 0x123452B7 (lui x5,0x12345) -> imm=0x12345000, fmt=4; push 0x402081B3 (sub) -> func=4'b0001, fmt=0.
REQ-037 SHALL, with out_ready=0, push DEPTH words -> count=DEPTH, in_ready=0; a further push is ignored; one pop -> in_ready=1, order preserved.
REQ-038 SHALL push 0x00000000 -> illegal=1, fmt=7; flush asserted with the queue full -> count=0 and out_valid=0 next cycle; reset_n pulled low mid-stream -> all outputs 0 immediately.
